// File: rtl/operand_unpacker_if.sv
// operand_unpacker_if: bundle between the operand producer, the operand
// unpacker and the multiply-adder.
//
// Input side (producer -> unpacker):
//   a_packed, b_packed, c_in, bitSizeA, bitSizeB, valid_in, ready_in.
// Output side (unpacker -> multiply-adder):
//   row, column, C_out, bitSizeA_o, bitSizeB_o, valid_out, ready_out,
//   and err_o, which pulses when an illegal transfer is dropped.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The sender holds its payload stable while valid is high and
// ready is low. Ready may be high while valid is low.
//
// Modports: slave is the unpacker's view. master is the view of the
// environment that drives both neighbours.
interface operand_unpacker_if #(
    parameter int K         = 2,
    parameter int MAX_WIDTH = 16,
    parameter int P         = 2,
    parameter int BS_W      = $clog2(MAX_WIDTH / P) + 2
);
    logic [K*MAX_WIDTH-1:0]        a_packed;
    logic [K*MAX_WIDTH-1:0]        b_packed;
    logic [31:0]                   c_in;
    logic [BS_W-1:0]               bitSizeA;
    logic [BS_W-1:0]               bitSizeB;
    logic                          valid_in;
    logic                          ready_in;
    logic signed [MAX_WIDTH-1:0]   row [K];
    logic signed [MAX_WIDTH-1:0]   column [K];
    logic [31:0]                   C_out;
    logic [BS_W-1:0]               bitSizeA_o;
    logic [BS_W-1:0]               bitSizeB_o;
    logic                          valid_out;
    logic                          ready_out;
    logic                          err_o;

    modport slave (
        input  a_packed, b_packed, c_in, bitSizeA, bitSizeB, valid_in, ready_out,
        output ready_in, row, column, C_out, bitSizeA_o, bitSizeB_o, valid_out, err_o
    );

    modport master (
        output a_packed, b_packed, c_in, bitSizeA, bitSizeB, valid_in, ready_out,
        input  ready_in, row, column, C_out, bitSizeA_o, bitSizeB_o, valid_out, err_o
    );
endinterface

// File: rtl/operand_unpacker.sv
// operand_unpacker: staging stage in front of the sequential multiply-adder.
//
// Each accepted transfer carries K packed A elements and K packed B elements.
// Their widths are bitSizeA*P and bitSizeB*P bits. Every element is
// sign-extended to MAX_WIDTH and stored with the accumulator seed and both
// precisions in a DEPTH-entry FIFO. A transfer whose precision is out of range
// is still accepted, but it is not stored. err_o is then high for one cycle.
//
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   bus     operand_unpacker_if.slave (input transfer, head entry, err_o)
module operand_unpacker #(
    parameter int K         = 2,
    parameter int MAX_WIDTH = 16,
    parameter int P         = 2,
    parameter int DEPTH     = 2,
    parameter int BS_W      = $clog2(MAX_WIDTH / P) + 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    operand_unpacker_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);
    localparam logic [31:0]      MAX_BS = 32'(MAX_WIDTH / P);

    typedef struct packed {
        logic [K-1:0][MAX_WIDTH-1:0] row;
        logic [K-1:0][MAX_WIDTH-1:0] column;
        logic [31:0]                 c;
        logic [BS_W-1:0]             bs_a;
        logic [BS_W-1:0]             bs_b;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             err_q;
    logic             ready;
    logic             valid;
    logic             legal;
    logic             push;
    logic             enq;
    logic             pop;

    // Move element idx of width bs*P to the bottom of the word. Shift it up to
    // the MSB, then shift it back down arithmetically. That replicates its sign
    // bit without a variable-width part-select.
    function automatic logic [MAX_WIDTH-1:0] unpack_elem(
        input logic [K*MAX_WIDTH-1:0] packed_v,
        input logic [BS_W-1:0]        bs,
        input int                     idx
    );
        logic [31:0]                 w;
        logic [31:0]                 sh;
        logic [K*MAX_WIDTH-1:0]      shifted;
        logic [MAX_WIDTH-1:0]        t;
        logic signed [MAX_WIDTH-1:0] s;
        w       = 32'(bs) * 32'(P);
        sh      = 32'(MAX_WIDTH) - w;
        shifted = packed_v >> (32'(idx) * w);
        t       = shifted[MAX_WIDTH-1:0] << sh;
        s       = $signed(t) >>> sh;
        return $unsigned(s);
    endfunction

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic bs_legal(input logic [BS_W-1:0] bs);
        return (bs != '0) && (32'(bs) <= MAX_BS);
    endfunction

    always_comb begin
        in_entry      = '0;
        in_entry.c    = bus.c_in;
        in_entry.bs_a = bus.bitSizeA;
        in_entry.bs_b = bus.bitSizeB;
        for (int i = 0; i < K; i++) begin
            in_entry.row[i]    = unpack_elem(bus.a_packed, bus.bitSizeA, i);
            in_entry.column[i] = unpack_elem(bus.b_packed, bus.bitSizeB, i);
        end
    end

    // ready drops while in reset. A pop in the same cycle does not reopen a
    // full FIFO.
    assign ready = (count != FULL) & rst_ni;
    assign valid = (count != '0);
    assign legal = bs_legal(bus.bitSizeA) & bs_legal(bus.bitSizeB);
    assign push  = bus.valid_in & ready;
    assign enq   = push & legal;
    assign pop   = valid & bus.ready_out;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= push & ~legal;
            if (enq) wr_ptr <= bump(wr_ptr);
            if (pop) rd_ptr <= bump(rd_ptr);
            if (enq && !pop)      count <= count + 1'b1;
            else if (!enq && pop) count <= count - 1'b1;
        end
    end

    // The storage is never reset. Stale contents cannot be seen because the
    // head is forced to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wr_ptr] <= in_entry;
    end

    assign head = valid ? mem[rd_ptr] : '0;

    always_comb begin
        for (int i = 0; i < K; i++) begin
            bus.row[i]    = $signed(head.row[i]);
            bus.column[i] = $signed(head.column[i]);
        end
    end

    assign bus.ready_in   = ready;
    assign bus.valid_out  = valid;
    assign bus.C_out      = head.c;
    assign bus.bitSizeA_o = head.bs_a;
    assign bus.bitSizeB_o = head.bs_b;
    assign bus.err_o      = err_q;
endmodule
